video_fetch_fifo: RTL and testbench
===================================

Name: video_fetch_fifo

Overview:
- Parametrised successor to the video fetch register. Assembles 16-bit DRAM video words into a fetch word of LANES×16 bits, using per-byte write enables and per-byte high/low source selection.
- Queues completed words in a small FIFO of DEPTH entries, so DRAM fetch bursts are decoupled from the renderer's fetch_stb.
- Sits between the DRAM video port and the video renderers.

Parameters:
- LANES, 2: number of 16-bit lanes; fetch word width W = 16*LANES; legal 1..8.
- DEPTH, 4: number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1: system clock.
- res  in  1: synchronous reset, active-high.
- video_strobe  in  1: DRAM data valid this cycle.
- video_data  in  16: DRAM read data.
- f_sel  in  2*LANES: byte write enables into the assembly register; bit i selects byte i.
- b_sel  in  2*LANES: per-byte source; 1 = video_data[15:8], 0 = video_data[7:0].
- f_last  in  1: qualifies video_strobe; pushes the completed word this cycle.
- fetch_stb  in  1: pop request from the renderer.
- fetch_data  out  W: registered popped word.
- fetch_temp  out  W: current assembly register.
- fifo_level  out  $clog2(DEPTH+1): number of occupied entries.
- fifo_empty  out  1: fifo_level == 0.
- fifo_full  out  1: fifo_level == DEPTH.
- ovf_err  out  1: sticky flag, push dropped while full.
- udf_err  out  1: sticky flag, pop while empty.
- err_clr  in  1: clears both sticky flags.

Behaviour:
- Reset: fetch_temp = 0, fetch_data = 0, read/write pointers = 0, fifo_level = 0, fifo_empty = 1, fifo_full = 0, ovf_err = 0, udf_err = 0.
  - Reset mid-operation discards all queued words and any partial assembly.
  - While res = 1, all other inputs are ignored.
- Assembly, on video_strobe = 1:
  - Each byte i with f_sel[i] = 1 loads video_data[15:8] when b_sel[i] = 1, otherwise video_data[7:0].
  - Unselected bytes hold their value.
  - fetch_temp is never cleared except by reset; it persists across pushes.
- Push condition: video_strobe & f_last.
  - The pushed word is the next value of fetch_temp, i.e. it includes this cycle's byte writes.
  - Accepted if !fifo_full, or if a valid pop occurs in the same cycle.
  - If fifo_full and no pop: the word is dropped, ovf_err is set, and the assembly register still updates.
- Pop condition: fetch_stb.
  - If !fifo_empty: fetch_data <= head entry on that edge (1-cycle latency) and the read pointer advances.
  - If fifo_empty: fetch_data holds and udf_err is set. There is no bypass: a push in the same cycle is stored, and the pop still counts as an underflow.
- Simultaneous valid push and pop: fifo_level is unchanged and order is preserved.
  - At full, this is a legal pass-through with no ovf_err.
  - At level 1, the popped word is the old head.
- Pointers wrap modulo DEPTH.
- fifo_level, fifo_full and fifo_empty are registered and consistent with the post-edge state.
- Sticky flags:
  - err_clr clears ovf_err and udf_err.
  - A new error event in the same cycle as err_clr wins, so the flag stays 1.
- Storage is a register array (DEPTH × W); there is no reset of the array contents.
- Legacy compatibility: LANES = 2, DEPTH = 1-style use with b_sel[3:2] = 2'b10 reproduces the previous fixed lane-2/3 mapping.

Test Plan:
- Legacy mapping (LANES=2, DEPTH=4): video_data = 16'hA1B2, f_sel = 4'b1111, b_sel = 4'b1010, f_last = 1, then fetch_stb -> fetch_data = 32'hA1B2A1B2; fifo_level goes 1 then 0.
- Two-strobe assembly: first strobe 16'h1234, f_sel = 4'b0011, b_sel = 4'b0010, f_last = 0; second strobe 16'h5678, f_sel = 4'b1100, b_sel = 4'b1000, f_last = 1 -> fifo_level = 1; pop gives 32'h56781234.
- Fill and overflow: push 32'h1, 2, 3, 4 -> fifo_full = 1. A 5th push (32'h5) with no pop -> dropped, ovf_err = 1, fifo_level = 4. Four pops -> 1, 2, 3, 4 in order, then fifo_empty = 1.
- Full pass-through: at fifo_level = 4, push 32'hAA and pop in the same cycle -> fetch_data = oldest entry, fifo_level = 4, ovf_err = 0. After draining, 32'hAA comes out last.
- Underflow and sticky clear: pop while empty -> fetch_data unchanged, udf_err = 1. err_clr alone -> 0. err_clr together with a new empty pop -> udf_err stays 1.
- Reset mid-operation: at fifo_level = 3 with fetch_temp nonzero, assert res for 1 cycle -> all outputs at reset values. The next pop underflows and fetch_data = 0.

Source files
------------

// File: rtl/video_fetch_fifo.sv
// video_fetch_fifo: assembles 16-bit DRAM video words into LANES*16-bit fetch words and queues them for the renderer
module video_fetch_fifo #(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         video_strobe,
    input  logic [15:0]                  video_data,
    input  logic [2*LANES-1:0]           f_sel,
    input  logic [2*LANES-1:0]           b_sel,
    input  logic                         f_last,
    input  logic                         fetch_stb,
    input  logic                         err_clr,
    output logic [16*LANES-1:0]          fetch_data,
    output logic [16*LANES-1:0]          fetch_temp,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic                         ovf_err,
    output logic                         udf_err
);
    localparam int W  = 16*LANES;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [W-1:0]  temp_nx;
    logic [LW-1:0] level_nx;
    logic          push_req, pop, push, ovf_ev, udf_ev;
    always_comb begin
        temp_nx = fetch_temp;
        for (int i = 0; i < 2*LANES; i++)
            if (video_strobe && f_sel[i])
                temp_nx[8*i +: 8] = b_sel[i] ? video_data[15:8] : video_data[7:0];
    end
    // a pop frees the head slot in the same edge, so a full FIFO can still accept
    assign push_req = video_strobe & f_last;
    assign pop      = fetch_stb & ~fifo_empty;
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_ev   = push_req & fifo_full & ~pop;
    assign udf_ev   = fetch_stb & fifo_empty;
    assign level_nx = fifo_level + LW'(push) - LW'(pop);
    always_ff @(posedge clk)
        if (!res && push) mem[wptr] <= temp_nx;
    always_ff @(posedge clk) begin
        if (res) begin
            fetch_temp <= '0;
            fetch_data <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            fetch_temp <= temp_nx;
            if (pop) fetch_data <= mem[rptr];
            if (push) wptr <= AW'((int'(wptr) + 1) % DEPTH);
            if (pop) rptr <= AW'((int'(rptr) + 1) % DEPTH);
            fifo_level <= level_nx;
            fifo_empty <= level_nx == '0;
            fifo_full  <= level_nx == LW'(DEPTH);
            ovf_err    <= ovf_ev | (ovf_err & ~err_clr);
            udf_err    <= udf_ev | (udf_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_video_fetch_fifo.sv
// tb_video_fetch_fifo: directed checks of assembly, queueing, error flags and reset for video_fetch_fifo
module tb_video_fetch_fifo;
    logic        clk = 1'b0;
    logic        res, video_strobe, f_last, fetch_stb, err_clr;
    logic [15:0] video_data;
    logic [3:0]  f_sel, b_sel;
    logic [31:0] fetch_data, fetch_temp;
    logic [2:0]  fifo_level;
    logic        fifo_empty, fifo_full, ovf_err, udf_err;
    int          total = 0, passed = 0;
    video_fetch_fifo #(.LANES(2), .DEPTH(4)) dut (
        .clk(clk), .res(res), .video_strobe(video_strobe), .video_data(video_data),
        .f_sel(f_sel), .b_sel(b_sel), .f_last(f_last), .fetch_stb(fetch_stb),
        .err_clr(err_clr), .fetch_data(fetch_data), .fetch_temp(fetch_temp),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic step(input logic vs, input logic [15:0] vd, input logic [3:0] fs,
                        input logic [3:0] bs, input logic fl, input logic pp,
                        input logic ec, input logic r);
        video_strobe = vs; video_data = vd; f_sel = fs; b_sel = bs;
        f_last = fl; fetch_stb = pp; err_clr = ec; res = r;
        @(posedge clk);
        #1;
        video_strobe = 0; video_data = '0; f_sel = '0; b_sel = '0;
        f_last = 0; fetch_stb = 0; err_clr = 0; res = 0;
    endtask
    // whole-word push of 32'h000000XX: upper bytes take the zero high byte
    task automatic push_b(input logic [7:0] b, input logic pp);
        step(1, {8'h00, b}, 4'hF, 4'b1110, 1, pp, 0, 0);
    endtask
    task automatic pop_only();
        step(0, '0, '0, '0, 0, 1, 0, 0);
    endtask
    initial begin
        step(0, '0, '0, '0, 0, 0, 0, 1);
        chk("rst_temp", fetch_temp, 0);
        chk("rst_data", fetch_data, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_udf", 32'(udf_err), 0);
        step(1, 16'hA1B2, 4'hF, 4'b1010, 1, 0, 0, 0);
        chk("legacy_temp", fetch_temp, 32'hA1B2A1B2);
        chk("legacy_lvl1", 32'(fifo_level), 1);
        pop_only();
        chk("legacy_data", fetch_data, 32'hA1B2A1B2);
        chk("legacy_lvl0", 32'(fifo_level), 0);
        chk("legacy_empty", 32'(fifo_empty), 1);
        step(1, 16'h1234, 4'b0011, 4'b0010, 0, 0, 0, 0);
        chk("two_temp1", fetch_temp, 32'hA1B21234);
        chk("two_lvl0", 32'(fifo_level), 0);
        step(1, 16'h5678, 4'b1100, 4'b1000, 1, 0, 0, 0);
        chk("two_lvl1", 32'(fifo_level), 1);
        pop_only();
        chk("two_data", fetch_data, 32'h56781234);
        for (int i = 1; i <= 4; i++) push_b(8'(i), 0);
        chk("fill_full", 32'(fifo_full), 1);
        chk("fill_lvl", 32'(fifo_level), 4);
        chk("fill_ovf0", 32'(ovf_err), 0);
        push_b(8'h05, 0);
        chk("ovf_flag", 32'(ovf_err), 1);
        chk("ovf_lvl", 32'(fifo_level), 4);
        chk("ovf_temp", fetch_temp, 32'h5);
        for (int i = 1; i <= 4; i++) begin
            pop_only();
            chk($sformatf("drain%0d", i), fetch_data, 32'(i));
        end
        chk("drain_empty", 32'(fifo_empty), 1);
        chk("drain_udf0", 32'(udf_err), 0);
        step(0, '0, '0, '0, 0, 0, 1, 0);
        chk("ovf_clr", 32'(ovf_err), 0);
        for (int i = 1; i <= 4; i++) push_b(8'(8'h10 + i), 0);
        push_b(8'hAA, 1);
        chk("pass_data", fetch_data, 32'h11);
        chk("pass_lvl", 32'(fifo_level), 4);
        chk("pass_full", 32'(fifo_full), 1);
        chk("pass_ovf", 32'(ovf_err), 0);
        for (int i = 2; i <= 4; i++) begin
            pop_only();
            chk($sformatf("pass_drain%0d", i), fetch_data, 32'(8'h10 + i));
        end
        pop_only();
        chk("pass_last", fetch_data, 32'hAA);
        chk("pass_empty", 32'(fifo_empty), 1);
        pop_only();
        chk("udf_hold", fetch_data, 32'hAA);
        chk("udf_flag", 32'(udf_err), 1);
        step(0, '0, '0, '0, 0, 0, 1, 0);
        chk("udf_clr", 32'(udf_err), 0);
        step(0, '0, '0, '0, 0, 1, 1, 0);
        chk("udf_clr_win", 32'(udf_err), 1);
        step(0, '0, '0, '0, 0, 0, 1, 0);
        push_b(8'h21, 0);
        push_b(8'h22, 1);
        chk("lvl1_pp_data", fetch_data, 32'h21);
        chk("lvl1_pp_lvl", 32'(fifo_level), 1);
        pop_only();
        chk("lvl1_pp_next", fetch_data, 32'h22);
        push_b(8'h31, 1);
        chk("empty_pp_udf", 32'(udf_err), 1);
        chk("empty_pp_lvl", 32'(fifo_level), 1);
        chk("empty_pp_hold", fetch_data, 32'h22);
        pop_only();
        chk("empty_pp_data", fetch_data, 32'h31);
        push_b(8'h41, 0);
        push_b(8'h42, 0);
        push_b(8'h43, 0);
        chk("pre_rst_lvl", 32'(fifo_level), 3);
        chk("pre_rst_temp", fetch_temp, 32'h43);
        step(1, 16'hFFFF, 4'hF, 4'hF, 1, 1, 0, 1);
        chk("mid_rst_temp", fetch_temp, 0);
        chk("mid_rst_data", fetch_data, 0);
        chk("mid_rst_lvl", 32'(fifo_level), 0);
        chk("mid_rst_empty", 32'(fifo_empty), 1);
        chk("mid_rst_full", 32'(fifo_full), 0);
        chk("mid_rst_udf", 32'(udf_err), 0);
        chk("mid_rst_ovf", 32'(ovf_err), 0);
        pop_only();
        chk("post_rst_udf", 32'(udf_err), 1);
        chk("post_rst_data", fetch_data, 0);
        chk("post_rst_lvl", 32'(fifo_level), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
